// File: rtl/sqrt_arb_pkg.sv
// Shared types and constants for the square-root request arbiter.
package sqrt_arb_pkg;

  localparam int ARG_W           = 8;
  localparam int RES_W           = 4;
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } sqrt_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: the first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx
);

  logic             w_found;
  logic [PTR_W-1:0] w_cand;

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= NUM_REQ) ? s - NUM_REQ : s;
  endfunction

  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = PTR_W'(wrap_idx(int'(ptr), i));
      if (en && !w_found && req[w_cand]) begin
        w_found     = 1'b1;
        gnt[w_cand] = 1'b1;
        idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one external sqrt_conv unit among NUM_REQ requesters with round-robin
// acceptance, a single-cycle issue strobe and a bounded wait for the result.
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][ARG_W-1:0]  req_arg,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [RES_W-1:0]               rsp_res,
  output logic                           rsp_timeout,
  output logic [ARG_W-1:0]               arg,
  output logic                           arg_valid,
  input  logic                           sqrt_valid,
  input  logic [RES_W-1:0]               sqrt_res,
  output logic                           busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  sqrt_arb_state_t     r_state, w_next_state;
  logic [PW-1:0]       r_ptr, r_gnt_idx;
  logic [CW-1:0]       r_cnt;
  logic [ARG_W-1:0]    r_arg;
  logic                r_arg_valid;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [RES_W-1:0]    r_rsp_res;
  logic                r_rsp_timeout;
  logic                r_busy;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [PW-1:0]       w_gnt_idx;
  logic                w_gnt_en;
  logic                w_accept;
  logic                w_cnt_last;

  // Counter holds at its terminal value instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_LAST) ? v : v + CW'(1);
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] v);
    return (v == PW'(NUM_REQ - 1)) ? '0 : v + PW'(1);
  endfunction

  assign w_gnt_en   = (r_state == IDLE) && !reset;
  assign w_accept   = |(w_gnt & req_valid);
  assign w_cnt_last = (r_cnt == CNT_LAST);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PW)
  ) u_rr (
    .req (req_valid),
    .ptr (r_ptr),
    .en  (w_gnt_en),
    .gnt (w_gnt),
    .idx (w_gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = ISSUE;
      ISSUE:   w_next_state = WAIT;
      WAIT:    if (sqrt_valid || w_cnt_last) w_next_state = RESPOND;
      RESPOND: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Registered outputs; sqrt_valid wins over a coincident timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr         <= '0;
      r_arg         <= '0;
      r_arg_valid   <= 1'b0;
      r_rsp_valid   <= '0;
      r_rsp_res     <= '0;
      r_rsp_timeout <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_arg_valid <= (r_state == IDLE) && w_accept;
      r_rsp_valid <= '0;
      r_busy      <= (w_next_state != IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_arg     <= req_arg[w_gnt_idx];
            r_gnt_idx <= w_gnt_idx;
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          r_cnt <= sat_inc(r_cnt);
          if (sqrt_valid) begin
            r_rsp_res     <= sqrt_res;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= NUM_REQ'(1) << r_gnt_idx;
          end else if (w_cnt_last) begin
            r_rsp_res     <= '0;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= NUM_REQ'(1) << r_gnt_idx;
          end
        end
        RESPOND: r_ptr <= next_ptr(r_gnt_idx);
        default: ;
      endcase
    end
  end

  assign req_ready   = w_gnt;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_res     = r_rsp_res;
  assign rsp_timeout = r_rsp_timeout;
  assign arg         = r_arg;
  assign arg_valid   = r_arg_valid;
  assign busy        = r_busy;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a behavioural sqrt_conv of programmable latency.
module tb_sqrt_arbiter;
  import sqrt_arb_pkg::*;

  localparam int N  = 4;
  localparam int TO = 64;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         req_valid;
  logic [N-1:0][7:0]    req_arg;
  logic [N-1:0]         req_ready;
  logic [N-1:0]         rsp_valid;
  logic [3:0]           rsp_res;
  logic                 rsp_timeout;
  logic [7:0]           arg;
  logic                 arg_valid;
  logic                 sqrt_valid;
  logic [3:0]           sqrt_res;
  logic                 busy;

  sqrt_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_arg     (req_arg),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_res     (rsp_res),
    .rsp_timeout (rsp_timeout),
    .arg         (arg),
    .arg_valid   (arg_valid),
    .sqrt_valid  (sqrt_valid),
    .sqrt_res    (sqrt_res),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int         n_checks  = 0;
  int         n_pass    = 0;
  int         cyc       = 0;
  int         rsp_count = 0;
  int         m_cnt     = 0;
  int         m_lat     = 3;
  logic       m_hold    = 1'b0;
  logic [7:0] m_arg     = '0;

  typedef struct {
    int         r;
    logic [7:0] a;
    int         lat;
    logic [3:0] res;
    logic       to;
    logic       hold;
  } vec_t;

  function automatic logic [3:0] isqrt(input logic [7:0] v);
    int k;
    k = 0;
    while ((k + 1) * (k + 1) <= int'(v)) k++;
    return 4'(k);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock: advance, then run the sqrt_conv model for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rsp_valid != '0) rsp_count++;
    sqrt_valid = 1'b0;
    sqrt_res   = 4'hA;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        sqrt_valid = 1'b1;
        sqrt_res   = isqrt(m_arg);
      end
    end
    if (arg_valid && !m_hold) begin
      m_arg = arg;
      m_cnt = m_lat;
    end
    #1;
  endtask

  task automatic wait_rsp(input string tag, input logic [N-1:0] ev, input logic [3:0] er,
                          input logic eto, input int bound);
    int n;
    n = 0;
    while (rsp_valid == '0 && n < bound) begin
      tick();
      n++;
    end
    check($sformatf("%s_rsp_seen", tag), {31'b0, rsp_valid != '0}, 32'd1);
    check($sformatf("%s_rsp_valid", tag), rsp_valid, ev);
    check($sformatf("%s_rsp_res", tag), rsp_res, er);
    check($sformatf("%s_rsp_timeout", tag), rsp_timeout, eto);
  endtask

  task automatic do_txn(input string tag, input int r, input logic [7:0] a, input int lat,
                        input logic [3:0] er, input logic eto, input logic hold);
    int t0;
    m_lat = lat;
    m_hold = hold;
    check($sformatf("%s_idle_busy", tag), busy, 0);
    req_arg[r] = a;
    req_valid  = N'(1) << r;
    #1;
    check($sformatf("%s_ready", tag), req_ready, N'(1) << r);
    t0 = cyc;
    tick();
    req_valid = '0;
    check($sformatf("%s_arg_valid", tag), arg_valid, 1);
    check($sformatf("%s_arg", tag), arg, a);
    wait_rsp(tag, N'(1) << r, er, eto, lat + TO + 8);
    check($sformatf("%s_latency", tag), cyc - t0, hold ? 2 + TO : 2 + lat);
    tick();
    check($sformatf("%s_rsp_done", tag), rsp_valid, 0);
    check($sformatf("%s_busy_after", tag), busy, 0);
  endtask

  vec_t       vecs[8];
  logic [3:0] cexp[4];
  int         rc;
  int         n;

  initial begin
    vecs[0] = '{r: 2, a: 8'd81,  lat: 3,  res: 4'd9,  to: 1'b0, hold: 1'b0};
    vecs[1] = '{r: 1, a: 8'd0,   lat: 1,  res: 4'd0,  to: 1'b0, hold: 1'b0};
    vecs[2] = '{r: 3, a: 8'd255, lat: 2,  res: 4'd15, to: 1'b0, hold: 1'b0};
    vecs[3] = '{r: 0, a: 8'd255, lat: 3,  res: 4'd0,  to: 1'b1, hold: 1'b1};
    vecs[4] = '{r: 0, a: 8'd0,   lat: 3,  res: 4'd0,  to: 1'b0, hold: 1'b0};
    vecs[5] = '{r: 3, a: 8'd100, lat: 64, res: 4'd10, to: 1'b0, hold: 1'b0};
    vecs[6] = '{r: 2, a: 8'd200, lat: 4,  res: 4'd14, to: 1'b0, hold: 1'b0};
    vecs[7] = '{r: 1, a: 8'd15,  lat: 1,  res: 4'd3,  to: 1'b0, hold: 1'b0};
    cexp[0] = 4'd4; cexp[1] = 4'd5; cexp[2] = 4'd6; cexp[3] = 4'd7;

    reset      = 1'b1;
    sqrt_valid = 1'b0;
    sqrt_res   = '0;
    req_valid  = 4'hF;
    req_arg[0] = 8'd16; req_arg[1] = 8'd25; req_arg[2] = 8'd36; req_arg[3] = 8'd49;
    tick();
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_arg", arg, 0);
    check("rst_arg_valid", arg_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_res", rsp_res, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);

    // Contention: all four pending, served in index order.
    reset = 1'b0;
    m_lat = 2;
    #1;
    for (int k = 0; k < N; k++) begin
      n = 0;
      while (req_ready == '0 && n < 200) begin
        tick();
        n++;
      end
      check($sformatf("cont%0d_grant", k), req_ready, N'(1) << k);
      tick();
      req_valid[k] = 1'b0;
      check($sformatf("cont%0d_arg", k), arg, req_arg[k]);
      wait_rsp($sformatf("cont%0d", k), N'(1) << k, cexp[k], 1'b0, 100);
    end
    tick();

    for (int i = 0; i < 8; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].r, vecs[i].a, vecs[i].lat,
             vecs[i].res, vecs[i].to, vecs[i].hold);

    // Rotation: requester 1 was served last, so 3 beats 0.
    m_lat = 2;
    m_hold = 1'b0;
    req_arg[0] = 8'd4;
    req_arg[3] = 8'd9;
    req_valid  = 4'b1001;
    #1;
    check("rot_first_grant", req_ready, 4'b1000);
    tick();
    req_valid[3] = 1'b0;
    wait_rsp("rot_first", 4'b1000, 4'd3, 1'b0, 100);
    n = 0;
    while (req_ready == '0 && n < 100) begin
      tick();
      n++;
    end
    check("rot_second_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    wait_rsp("rot_second", 4'b0001, 4'd2, 1'b0, 100);
    tick();

    // Reset during WAIT, then a stray sqrt_valid in IDLE.
    m_hold = 1'b1;
    req_arg[1] = 8'd100;
    req_valid  = 4'b0010;
    #1;
    tick();
    req_valid = '0;
    tick();
    tick();
    check("mid_busy", busy, 1);
    rc = rsp_count;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_arg", arg, 0);
    repeat (4) tick();
    sqrt_valid = 1'b1;
    sqrt_res   = 4'h7;
    tick();
    tick();
    tick();
    check("spur_busy", busy, 0);
    check("spur_rsp_valid", rsp_valid, 0);
    check("spur_no_rsp", rsp_count, rc);
    do_txn("post_rst", 2, 8'd144, 3, 4'd12, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got %0d checks", n_checks);
    $fatal(1);
  end

endmodule
